// File: rtl/out_ctrl_if.sv
// Downstream result stream from out_ctrl: saturated column data with valid/ready handshake.
interface out_ctrl_if #(
  parameter int datatype_size = 8
);
  logic signed [datatype_size-1:0] o_data;
  logic                            o_valid;
  logic                            i_ready;

  modport master (output o_data, output o_valid, input i_ready);
  modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/out_ctrl.sv
// CIM result-side controller: reads each output column from all vertical tiles,
// sums the partial sums, saturates to the output width and streams it downstream.
module out_ctrl #(
  parameter int datatype_size  = 8,
  parameter int psum_size      = 16,
  parameter int xbar_size      = 256,
  parameter int output_size    = 5,
  parameter int vertical_tiles = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_cim_done,
  output logic                                o_rd_en,
  output logic [$clog2(xbar_size)-1:0]        o_addr,
  input  logic signed [psum_size-1:0]         i_psum [vertical_tiles],
  output logic                                o_busy,
  output logic                                o_done,
  out_ctrl_if.master                          dn
);

  localparam int AW    = $clog2(xbar_size);
  localparam int SUM_W = psum_size + $clog2(vertical_tiles) + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (datatype_size - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_OUT
  } state_t;

  state_t                          state, next_state;
  logic [AW-1:0]                   addr;
  logic signed [datatype_size-1:0] data_q;
  logic                            done_q;
  logic signed [SUM_W-1:0]         sum;
  logic signed [datatype_size-1:0] sat;
  logic                            last_col;

  assign last_col = (addr == AW'(output_size - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (i_cim_done) next_state = S_READ;
      S_READ:  next_state = S_LATCH;
      S_LATCH: next_state = S_OUT;
      S_OUT:   if (dn.i_ready) next_state = last_col ? S_IDLE : S_READ;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_rd_en    = 1'b0;
    dn.o_valid = 1'b0;
    o_busy     = 1'b1;
    case (state)
      S_IDLE:  o_busy     = 1'b0;
      S_READ:  o_rd_en    = 1'b1;
      S_OUT:   dn.o_valid = 1'b1;
      default: ;
    endcase
  end

  // Sign-extend every tile's partial sum to the full accumulation width.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < unsigned'(vertical_tiles); i++)
      sum = sum + {{(SUM_W - psum_size){i_psum[i][psum_size-1]}}, i_psum[i]};
  end

  always_comb begin
    if (sum > SAT_MAX)      sat = SAT_MAX[datatype_size-1:0];
    else if (sum < SAT_MIN) sat = SAT_MIN[datatype_size-1:0];
    else                    sat = sum[datatype_size-1:0];
  end

  // Address returns to 0 on the final handshake so it reads 0 throughout S_IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr   <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE:  addr   <= '0;
        S_LATCH: data_q <= sat;
        S_OUT: begin
          if (dn.i_ready) begin
            if (last_col) begin
              addr   <= '0;
              done_q <= 1'b1;
            end else begin
              addr <= addr + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_addr    = addr;
  assign o_done    = done_q;
  assign dn.o_data = data_q;

endmodule
